// File: rtl/classic_seq_mul32_if.sv
// Operand/result handshake bundle for the sequential 32x32 multiplier.
// master = operand source + result consumer, slave = multiplier.
interface classic_seq_mul32_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/classic_seq_mul32.sv
// Sequential WIDTHxWIDTH unsigned multiplier: one 8x8 classic core,
// one byte pair per cycle, partials accumulated into a 2*WIDTH register.
module classic8 (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);
  always_comb begin
    p = '0;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p + (16'(x) << k);
    end
  end
endmodule

module classic_seq_mul32 #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  classic_seq_mul32_if.slave bus
);
  localparam int NB = WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    prod_r;
  logic [IW-1:0]    i;
  logic [IW-1:0]    j;
  logic             ir;
  logic             ov;
  logic             bz;

  logic [7:0]    xa;
  logic [7:0]    xb;
  logic [15:0]   p16;
  logic [IW:0]   sh;
  logic [PW-1:0] part;
  logic [PW-1:0] sum;

  always_comb begin
    xa   = a_r[{i, 3'b000} +: 8];
    xb   = b_r[{j, 3'b000} +: 8];
    sh   = {1'b0, i} + {1'b0, j};
    part = PW'(p16) << {sh, 3'b000};
    sum  = acc + part;
  end

  classic8 u_core (
    .x (xa),
    .y (xb),
    .p (p16)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      prod_r <= '0;
      i      <= '0;
      j      <= '0;
      ir     <= 1'b1;
      ov     <= 1'b0;
      bz     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && ir) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            ir    <= 1'b0;
            bz    <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= sum;
          if (i == LAST) begin
            i <= '0;
            // last byte pair: publish the completed sum directly
            if (j == LAST) begin
              j      <= '0;
              prod_r <= sum;
              ov     <= 1'b1;
              state  <= DONE;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov    <= 1'b0;
            ir    <= 1'b1;
            bz    <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ov    <= 1'b0;
          ir    <= 1'b1;
          bz    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = ir;
  assign bus.out_valid = ov;
  assign bus.product   = prod_r;
  assign bus.busy      = bz;
endmodule

// File: tb/tb_classic_seq_mul32.sv
// Scoreboard bench for classic_seq_mul32: directed corners,
// backpressure, reset abort and randomized back-to-back traffic.
module tb_classic_seq_mul32;
  localparam int LAT = 16;

  logic clk;
  logic rst_n;
  logic rnd_ready;
  logic rnd_bit;
  logic rdy_val;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  classic_seq_mul32_if #(.WIDTH(32)) bus ();

  classic_seq_mul32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.out_ready = rnd_ready ? rnd_bit : rdy_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rnd_bit <= ($urandom % 4) != 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // monitor: latency, hold under backpressure, in-order products
  initial begin
    logic        prev_ov;
    logic        prev_held;
    logic [63:0] prev_prod;
    prev_ov   = 1'b0;
    prev_held = 1'b0;
    prev_prod = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_ov   = 1'b0;
        prev_held = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov) begin
          if (lat_q.size() == 0) flag("unexpected_out_valid");
          else check("latency", 64'(cyc - lat_q.pop_front()), 64'(LAT));
        end
        if (bus.out_valid && prev_held)
          check("hold_product", bus.product, prev_prod);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) flag("extra_product");
          else check("product", bus.product, exp_q.pop_front());
        end
        prev_held = bus.out_valid && !bus.out_ready;
        prev_prod = bus.product;
        prev_ov   = bus.out_valid;
      end
    end
  end

  // call at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input bit junk);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      bus.in_valid = 1'b1;
      if (bus.in_ready) begin
        bus.a = x;
        bus.b = y;
        exp_q.push_back(64'(x) * 64'(y));
        lat_q.push_back(cyc + 1);
        done = 1'b1;
      end else if (junk) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end else begin
        bus.a = x;
        bus.b = y;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    if (!done) flag("accept_timeout");
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++)
      @(negedge clk);
    if (exp_q.size() != 0) flag("drain_timeout");
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({nm, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({nm, "_busy"}, 64'(bus.busy), 64'd0);
    check({nm, "_product"}, bus.product, 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 32'd0;
    if (s == 1) return 32'hFFFF_FFFF;
    if (s == 2) return 32'd1;
    return $urandom;
  endfunction

  logic [31:0] va[6];
  logic [31:0] vb[6];

  initial begin
    logic [63:0] bp_exp;
    bit          seen;
    n_cmp = 0;
    n_bad = 0;
    rnd_ready = 1'b0;
    rdy_val   = 1'b1;
    rst_n     = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;

    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    va[1] = 32'hDEAD_BEEF; vb[1] = 32'h0000_0001;
    va[2] = 32'h8000_0000; vb[2] = 32'h0000_0002;
    va[3] = 32'h0000_0000; vb[3] = 32'h1234_5678;
    va[4] = 32'h1234_5678; vb[4] = 32'h9ABC_DEF0;
    va[5] = 32'h0000_00FF; vb[5] = 32'hFF00_0000;

    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      issue(va[t], vb[t], 1'b0);
      wait_drain(60);
    end
    check("spec_ffff", 64'hFFFF_FFFF * 64'hFFFF_FFFF,
          64'hFFFF_FFFE_0000_0001);

    // backpressure: hold out_ready low for 5 cycles in DONE
    rdy_val = 1'b0;
    bp_exp  = 64'h8765_4321 * 64'h0BAD_F00D;
    issue(32'h8765_4321, 32'h0BAD_F00D, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) flag("bp_out_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_product", bus.product, bp_exp);
      @(negedge clk);
    end
    rdy_val = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_product_kept", bus.product, bp_exp);
    @(negedge clk);
    wait_drain(10);

    // reset in the middle of CALC
    issue(32'hCAFE_BABE, 32'h1357_9BDF, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("midreset_no_result", 64'(bus.out_valid), 64'd0);
    issue(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0);
    wait_drain(60);

    // randomized back-to-back traffic with random out_ready
    rnd_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(rnd_op(), rnd_op(), 1'b1);
    end
    wait_drain(200);
    rnd_ready = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
